// File: rtl/rioencoder_poller.sv
// Round-robin RS485 poll scheduler: sends one request byte per encoder slot, collects a
// 10-byte reply, validates it, retries failures and publishes good frames with health flags.
module rioencoder_poller #(
    parameter int ClkFrequency = 12000000,
    parameter int POLL_HZ      = 1000,
    parameter int NUM_ENC      = 4,
    parameter int TIMEOUT_CYC  = 2400,
    parameter int TURNAROUND   = 8,
    parameter int MAX_RETRY    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               de,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_endofpacket,
    output logic               frame_valid,
    output logic [2:0]         frame_id,
    output logic [63:0]        frame_data,
    output logic [NUM_ENC-1:0] stale,
    output logic [15:0]        crc_err_count,
    output logic [15:0]        timeout_count,
    output logic               overrun,
    output logic               busy,
    output logic [2:0]         state_dbg
);

    localparam int TICK_PERIOD = ClkFrequency / POLL_HZ;
    localparam int TICK_W      = $clog2(TICK_PERIOD + 1);
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int TURN_W      = $clog2(TURNAROUND + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_REQ  = 3'd1,
        TX_WAIT = 3'd2,
        TURN    = 3'd3,
        RX      = 3'd4,
        CHECK   = 3'd5,
        FAIL    = 3'd6,
        NEXT    = 3'd7
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [2:0]          slot;
    logic [3:0]          retry;
    logic                seen_busy;
    logic [TURN_W-1:0]   turn_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [3:0]          byte_cnt;
    logic [79:0]         shift_buf;
    logic                frame_ok;

    logic [79:0]         buf_next;
    logic [3:0]          cnt_next;
    logic [7:0]          xsum;
    logic                frame_ok_next;

    assign tick      = enable && (tick_cnt == TICK_W'(TICK_PERIOD - 1));
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Reply as it will look after this cycle's byte, so an end-of-packet strobe that
    // coincides with the last byte is judged on the complete frame.
    always_comb begin
        buf_next = shift_buf;
        cnt_next = byte_cnt;
        if (rx_valid && (byte_cnt < 4'd10)) begin
            buf_next = {shift_buf[71:0], rx_data};
            cnt_next = byte_cnt + 4'd1;
        end
        xsum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            xsum = xsum ^ buf_next[79-8*i -: 8];
        end
        frame_ok_next = (cnt_next == 4'd10) && (buf_next[15:8] == xsum) && (buf_next[7:0] == 8'h00);
    end

    // tx_start/tx_busy: a request is launched only when tx_busy is low; the UART then
    // raises tx_busy for the byte and drops it when the byte is on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            slot          <= '0;
            retry         <= '0;
            seen_busy     <= 1'b0;
            turn_cnt      <= '0;
            to_cnt        <= '0;
            byte_cnt      <= '0;
            shift_buf     <= '0;
            frame_ok      <= 1'b0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
            de            <= 1'b0;
            frame_valid   <= 1'b0;
            frame_id      <= '0;
            frame_data    <= '0;
            stale         <= '0;
            crc_err_count <= '0;
            timeout_count <= '0;
            overrun       <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            frame_valid <= 1'b0;
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        slot    <= '0;
                        retry   <= '0;
                        tx_data <= {4'hA, 1'b0, 3'd0};
                        de      <= 1'b1;
                        state   <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        seen_busy <= 1'b0;
                        state     <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (tx_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        // This cycle already counts as the first driver-hold cycle.
                        turn_cnt <= TURN_W'(1);
                        state    <= TURN;
                    end
                end
                TURN: begin
                    if (turn_cnt >= TURN_W'(TURNAROUND - 1)) begin
                        de        <= 1'b0;
                        byte_cnt  <= '0;
                        shift_buf <= '0;
                        to_cnt    <= '0;
                        state     <= RX;
                    end else begin
                        turn_cnt <= turn_cnt + TURN_W'(1);
                    end
                end
                RX: begin
                    shift_buf <= buf_next;
                    byte_cnt  <= cnt_next;
                    if (rx_endofpacket) begin
                        frame_ok <= frame_ok_next;
                        if (frame_ok_next) begin
                            frame_valid <= 1'b1;
                            frame_id    <= slot;
                            frame_data  <= buf_next[79:16];
                        end
                        state <= CHECK;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        if (timeout_count != 16'hFFFF) begin
                            timeout_count <= timeout_count + 16'd1;
                        end
                        state <= FAIL;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        for (int i = 0; i < NUM_ENC; i++) begin
                            if (slot == 3'(i)) stale[i] <= 1'b0;
                        end
                        state <= NEXT;
                    end else begin
                        if (crc_err_count != 16'hFFFF) begin
                            crc_err_count <= crc_err_count + 16'd1;
                        end
                        state <= FAIL;
                    end
                end
                FAIL: begin
                    if (retry < 4'(MAX_RETRY)) begin
                        retry   <= retry + 4'd1;
                        tx_data <= {4'hA, 1'b0, slot};
                        de      <= 1'b1;
                        state   <= TX_REQ;
                    end else begin
                        for (int i = 0; i < NUM_ENC; i++) begin
                            if (slot == 3'(i)) stale[i] <= 1'b1;
                        end
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    retry <= '0;
                    if ((slot == 3'(NUM_ENC - 1)) || !enable) begin
                        state <= IDLE;
                    end else begin
                        slot    <= slot + 3'd1;
                        tx_data <= {4'hA, 1'b0, slot + 3'd1};
                        de      <= 1'b1;
                        state   <= TX_REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rioencoder_poller.sv
// Bench for rioencoder_poller: a responder models the UART and encoders from a reply plan,
// monitors pop expected requests and frames from scoreboard queues as the DUT emits them.
module tb_rioencoder_poller;

    localparam int NUM_ENC     = 2;
    localparam int TIMEOUT_CYC = 2400;
    localparam int TURNAROUND  = 8;
    localparam int BUSY_CYC    = 10;

    localparam logic [95:0] GOOD    = 96'h010203040506070808000000;
    localparam logic [95:0] BAD     = 96'h010203040506070809000000;
    localparam logic [95:0] LONG    = 96'h01020304050607080800AABB;
    localparam logic [63:0] PAYLOAD = 64'h0102030405060708;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic               de;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_endofpacket;
    logic               frame_valid;
    logic [2:0]         frame_id;
    logic [63:0]        frame_data;
    logic [NUM_ENC-1:0] stale;
    logic [15:0]        crc_err_count;
    logic [15:0]        timeout_count;
    logic               overrun;
    logic               busy;
    logic [2:0]         state_dbg;

    rioencoder_poller #(
        .ClkFrequency(12000000),
        .POLL_HZ     (3000),
        .NUM_ENC     (NUM_ENC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TURNAROUND  (TURNAROUND),
        .MAX_RETRY   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .de            (de),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_endofpacket(rx_endofpacket),
        .frame_valid   (frame_valid),
        .frame_id      (frame_id),
        .frame_data    (frame_data),
        .stale         (stale),
        .crc_err_count (crc_err_count),
        .timeout_count (timeout_count),
        .overrun       (overrun),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_req_q[$];
    logic [66:0] exp_frm_q[$];
    int          plan_len_q[$];
    logic [95:0] plan_dat_q[$];
    bit          check_turn = 1'b1;
    int          gap_checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // scoreboard monitors
    logic eop_q = 1'b0;
    logic start_q = 1'b0;
    always @(negedge clk) begin
        if (tx_start) begin
            check("start_width", start_q, 1'b0);
            if (exp_req_q.size() == 0) flag_fail("req", $sformatf("got %0h expected none", tx_data));
            else check("req", tx_data, exp_req_q.pop_front());
        end
        if (frame_valid) begin
            check("frame_latency", eop_q, 1'b1);
            if (exp_frm_q.size() == 0) begin
                flag_fail("frame", $sformatf("got id %0d data %0h expected none", frame_id, frame_data));
            end else begin
                logic [66:0] e;
                e = exp_frm_q.pop_front();
                check("frame_id", frame_id, e[66:64]);
                check("frame_data", frame_data, e[63:0]);
            end
        end
        eop_q   = rx_endofpacket;
        start_q = tx_start;
    end

    // driver tasks
    task automatic uart_tx_byte();
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1 tx_busy = 1'b0;
    endtask

    task automatic send_reply(input int len, input logic [95:0] dat);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rx_data        = dat[95-8*i -: 8];
            rx_valid       = 1'b1;
            rx_endofpacket = (i == len - 1);
            @(posedge clk); #1;
            rx_valid       = 1'b0;
            rx_endofpacket = 1'b0;
        end
    endtask

    task automatic plan(input int len, input logic [95:0] dat);
        plan_len_q.push_back(len);
        plan_dat_q.push_back(dat);
    endtask

    // UART + encoder responder
    initial begin
        int n;
        int len;
        logic [95:0] dat;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                uart_tx_byte();
                n = 0;
                forever begin
                    @(negedge clk);
                    if (!de || n > 200) break;
                    n++;
                end
                if (check_turn) check("turnaround", n, TURNAROUND);
                if (plan_len_q.size() == 0) begin
                    flag_fail("plan", "request with no reply planned");
                end else begin
                    len = plan_len_q.pop_front();
                    dat = plan_dat_q.pop_front();
                    if (len > 0) begin
                        send_reply(len, dat);
                    end else begin
                        n = 1;
                        forever begin
                            @(negedge clk);
                            if (de || n > TIMEOUT_CYC + 100) break;
                            n++;
                        end
                        if (de) begin
                            gap_checks++;
                            check("silent_gap", n, TIMEOUT_CYC + 1);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_busy(input logic lvl, input int bound, input string name);
        int n = 0;
        while (busy !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) flag_fail(name, $sformatf("busy=%b after %0d cycles, required %b", busy, bound, lvl));
    endtask

    task automatic run_round(input string name);
        @(posedge clk); #1 enable = 1'b1;
        wait_busy(1'b1, 4200, {name, "_start"});
        wait_busy(1'b0, 20000, {name, "_end"});
        @(posedge clk); #1 enable = 1'b0;
        repeat (5) @(negedge clk);
        check({name, "_req_left"}, exp_req_q.size(), 0);
        check({name, "_frm_left"}, exp_frm_q.size(), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; tx_busy = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rx_endofpacket = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_de", de, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_stale", stale, 0);
        check("rst_crc", crc_err_count, 0);
        check("rst_timeout", timeout_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);

        // clean round
        plan(10, GOOD); plan(10, GOOD);
        exp_req_q.push_back(8'hA0); exp_req_q.push_back(8'hA1);
        exp_frm_q.push_back({3'd0, PAYLOAD}); exp_frm_q.push_back({3'd1, PAYLOAD});
        run_round("clean");
        check("clean_stale", stale, 2'b00);
        check("clean_crc", crc_err_count, 0);
        check("clean_timeout", timeout_count, 0);

        // bad checksum then recovery
        plan(10, BAD); plan(10, GOOD); plan(10, GOOD);
        exp_req_q.push_back(8'hA0); exp_req_q.push_back(8'hA0); exp_req_q.push_back(8'hA1);
        exp_frm_q.push_back({3'd0, PAYLOAD}); exp_frm_q.push_back({3'd1, PAYLOAD});
        run_round("badsum");
        check("badsum_crc", crc_err_count, 1);
        check("badsum_stale", stale, 2'b00);

        // 9-byte reply is a length error; 12-byte reply is judged on its first 10 bytes
        plan(9, GOOD); plan(10, GOOD); plan(12, LONG);
        exp_req_q.push_back(8'hA0); exp_req_q.push_back(8'hA0); exp_req_q.push_back(8'hA1);
        exp_frm_q.push_back({3'd0, PAYLOAD}); exp_frm_q.push_back({3'd1, PAYLOAD});
        run_round("length");
        check("length_crc", crc_err_count, 2);
        check("length_stale", stale, 2'b00);
        check("length_timeout", timeout_count, 0);

        // silent slot 1; the round outlasts the tick period so a tick lands mid-round
        plan(10, GOOD); plan(0, '0); plan(0, '0);
        exp_req_q.push_back(8'hA0); exp_req_q.push_back(8'hA1); exp_req_q.push_back(8'hA1);
        exp_frm_q.push_back({3'd0, PAYLOAD});
        run_round("silent");
        check("silent_timeout", timeout_count, 2);
        check("silent_stale", stale, 2'b10);
        check("silent_crc", crc_err_count, 2);
        check("silent_overrun", overrun, 1);
        check("silent_idle", state_dbg, 3'd0);
        check("silent_gap_seen", gap_checks, 1);

        // reset during TURN, then polling resumes from slot 0
        check_turn = 1'b0;
        plan(0, '0); plan(10, GOOD); plan(10, GOOD);
        exp_req_q.push_back(8'hA0);
        @(posedge clk); #1 enable = 1'b1;
        n = 0;
        while (state_dbg !== 3'd3 && n < 4500) begin
            @(negedge clk);
            n++;
        end
        if (state_dbg !== 3'd3) flag_fail("reach_turn", $sformatf("state=%0d required 3", state_dbg));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_de", de, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stale", stale, 0);
        check("mid_rst_crc", crc_err_count, 0);
        check("mid_rst_timeout", timeout_count, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_tx_data", tx_data, 0);
        repeat (20) @(negedge clk);
        check_turn = 1'b1;
        exp_req_q.push_back(8'hA0); exp_req_q.push_back(8'hA1);
        exp_frm_q.push_back({3'd0, PAYLOAD}); exp_frm_q.push_back({3'd1, PAYLOAD});
        wait_busy(1'b1, 4200, "resume_start");
        wait_busy(1'b0, 20000, "resume_end");
        @(posedge clk); #1 enable = 1'b0;
        repeat (5) @(negedge clk);
        check("resume_req_left", exp_req_q.size(), 0);
        check("resume_frm_left", exp_frm_q.size(), 0);
        check("resume_stale", stale, 2'b00);
        check("resume_overrun", overrun, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
